// File: rtl/pipe_stage_fifo_pkg.sv
// Shared constants and pointer-control helpers for the inter-stage FIFO buffer.
// Used by the top, the pointer sub-module and the checker.
package pipe_stage_fifo_pkg;

    localparam int IF_TO_IPD_BUS_WD = 64;
    localparam int IQ_DEPTH         = 4;

    typedef enum logic [1:0] {
        PTR_HOLD = 2'd0,
        PTR_INC  = 2'd1,
        PTR_CLR  = 2'd2
    } ptr_op_e;

    // Clear always wins over increment so a redirect leaves both pointers at slot 0.
    function automatic ptr_op_e ptr_op(input logic clr, input logic inc);
        ptr_op_e op_s;
        if (clr) begin
            op_s = PTR_CLR;
        end else if (inc) begin
            op_s = PTR_INC;
        end else begin
            op_s = PTR_HOLD;
        end
        return op_s;
    endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// Circular-buffer pointer: increments on request, wraps DEPTH-1 -> 0 by explicit compare,
// so DEPTH need not be a power of two.
module pipe_fifo_ptr
    import pipe_stage_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  ptr_op_e           op,
    output logic [PTR_WD-1:0] ptr
);

    localparam logic [PTR_WD-1:0] LAST_PTR = PTR_WD'(DEPTH - 1);

    logic [PTR_WD-1:0] ptr_r;

    // Pointer register with clear, increment and explicit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else begin
            case (op)
                PTR_CLR: ptr_r <= '0;
                PTR_INC: ptr_r <= (ptr_r == LAST_PTR) ? '0 : ptr_r + PTR_WD'(1);
                default: ptr_r <= ptr_r;
            endcase
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/pipe_stage_fifo_chk.sv
// Simulation-only protocol checker for pipe_stage_fifo occupancy and handshakes.
module pipe_stage_fifo_chk
    import pipe_stage_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_WD = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    input logic [CNT_WD-1:0] count,
    input logic              push,
    input logic              pop,
    input logic              out_valid
);

    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);

    a_count_max: assert property (@(posedge clk) disable iff (reset)
        count <= FULL_CNT);

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == FULL_CNT)));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && !out_valid));

endmodule

// File: rtl/pipe_stage_fifo.sv
// Parametrised FIFO replacing the single valid/allow_in stage register between two
// pipeline stages, with flush for redirects and optional fall-through when empty.
module pipe_stage_fifo
    import pipe_stage_fifo_pkg::*;
#(
    parameter int DATA_WD      = IF_TO_IPD_BUS_WD,
    parameter int DEPTH        = IQ_DEPTH,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int CNT_WD       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_WD-1:0] in_bus,
    output logic               allow_in,
    output logic               out_valid,
    output logic [DATA_WD-1:0] out_bus,
    input  logic               next_allow_in,
    output logic [CNT_WD-1:0]  count
);

    localparam int                PTR_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);
    localparam logic [CNT_WD-1:0] ZERO_CNT = '0;

    logic [DATA_WD-1:0] mem_r [DEPTH];
    logic [PTR_WD-1:0]  rd_ptr_s;
    logic [PTR_WD-1:0]  wr_ptr_s;
    logic [CNT_WD-1:0]  count_r;
    logic [CNT_WD-1:0]  count_nxt_s;
    logic               allow_in_r;
    logic               not_empty_r;
    logic               bypass_s;
    logic               out_valid_s;
    logic [DATA_WD-1:0] out_bus_s;
    logic               push_s;
    logic               pop_s;
    logic               pass_s;
    logic               wr_s;
    logic               rd_s;

    // Head selection: the upstream entry is forwarded directly only in fall-through mode when empty.
    always_comb begin
        bypass_s = FALL_THROUGH & ~not_empty_r;
        if (bypass_s) begin
            out_valid_s = in_valid & ~flush;
            out_bus_s   = in_bus;
        end else begin
            out_valid_s = not_empty_r;
            out_bus_s   = mem_r[rd_ptr_s];
        end
    end

    // Handshake decode; a bypassed entry consumed in its push cycle never touches storage.
    always_comb begin
        push_s = in_valid & allow_in_r & ~flush;
        pop_s  = out_valid_s & next_allow_in & ~flush;
        pass_s = bypass_s & push_s & pop_s;
        wr_s   = push_s & ~pass_s;
        rd_s   = pop_s & ~pass_s;
        case ({wr_s, rd_s})
            2'b10:   count_nxt_s = count_r + CNT_WD'(1);
            2'b01:   count_nxt_s = count_r - CNT_WD'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy plus registered full/empty flags so allow_in has no path from downstream.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_r     <= ZERO_CNT;
            allow_in_r  <= 1'b1;
            not_empty_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            allow_in_r  <= (count_nxt_s != FULL_CNT);
            not_empty_r <= (count_nxt_s != ZERO_CNT);
        end
    end

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_s] <= in_bus;
        end
    end

    pipe_fifo_ptr #(
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .op    (ptr_op(flush, wr_s)),
        .ptr   (wr_ptr_s)
    );

    pipe_fifo_ptr #(
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .op    (ptr_op(flush, rd_s)),
        .ptr   (rd_ptr_s)
    );

    pipe_stage_fifo_chk #(
        .DEPTH  (DEPTH),
        .CNT_WD (CNT_WD)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .count     (count_r),
        .push      (push_s),
        .pop       (pop_s),
        .out_valid (out_valid_s)
    );

    assign allow_in  = allow_in_r;
    assign out_valid = out_valid_s;
    assign out_bus   = out_bus_s;
    assign count     = count_r;

endmodule
